// File: rtl/ddr2idxbuf_if.sv
// ---------------------------------------------------------------------------
// ddr2idxbuf_if
//
// Groups the two data paths of the sparse-index loader:
//   * the DDR read stream    : ddr_data / ddr_valid in, ddr_ready back
//   * the index-buffer write : idx_wr_data / idx_wr_addr / idx_wr_en out
//
// Modports
//   slave  : the loader itself (consumes the DDR stream, drives the writes)
//   master : the environment (DDR read channel source + index-buffer sink)
//
// Parameters must match the ones given to ddr2idxbuf.
// ---------------------------------------------------------------------------
interface ddr2idxbuf_if #(
  parameter int DDR_W    = 512,
  parameter int IDX_W    = 16,
  parameter int BANK_NUM = 4,
  parameter int ADDR_W   = 8
);

  // DDR read stream
  logic [DDR_W-1:0]    ddr_data;
  logic                ddr_valid;
  logic                ddr_ready;

  // Index-buffer write port, shared data/addr with one strobe per bank
  logic [2*IDX_W-1:0]  idx_wr_data;
  logic [ADDR_W-1:0]   idx_wr_addr;
  logic [BANK_NUM-1:0] idx_wr_en;

  modport slave (
    input  ddr_data,
    input  ddr_valid,
    output ddr_ready,
    output idx_wr_data,
    output idx_wr_addr,
    output idx_wr_en
  );

  modport master (
    output ddr_data,
    output ddr_valid,
    input  ddr_ready,
    input  idx_wr_data,
    input  idx_wr_addr,
    input  idx_wr_en
  );

endinterface

// File: rtl/ddr2idxbuf.sv
// ---------------------------------------------------------------------------
// ddr2idxbuf
//
// Loads a configured number of index entries (index pairs, 2*IDX_W bits)
// from the DDR read stream into BANK_NUM index-buffer banks.  Every accepted
// beat carries IDX_BATCH = DDR_W/(2*IDX_W) entries which are written out one
// per cycle.  Distribution modes:
//   0 / 3 : broadcast   - all banks strobed, addr = n
//   1     : round-robin - bank = n mod BANK_NUM, addr = n / BANK_NUM
//   2     : single bank - bank = conf_bank,      addr = n
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse; latches conf_* and (re)starts a load
//   done            high from load completion until the next start
//   conf_mode       distribution mode (see above)
//   conf_bank       target bank for mode 2
//   conf_idx_num    number of entries N (clamped to bank capacity at start)
//   bus             ddr2idxbuf_if.slave: DDR stream in, index writes out
// ---------------------------------------------------------------------------
module ddr2idxbuf #(
  parameter int DDR_W     = 512,
  parameter int IDX_W     = 16,
  parameter int BANK_NUM  = 4,
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = $clog2(IDX_DEPTH),
  parameter int CNT_W     = ADDR_W + $clog2(BANK_NUM) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        done,
  input  logic [1:0]                  conf_mode,
  input  logic [$clog2(BANK_NUM)-1:0] conf_bank,
  input  logic [CNT_W-1:0]            conf_idx_num,
  ddr2idxbuf_if.slave                 bus
);

  localparam int ENT_W     = 2 * IDX_W;
  localparam int IDX_BATCH = DDR_W / ENT_W;
  localparam int BANK_W    = $clog2(BANK_NUM);
  localparam int SLOT_W    = (IDX_BATCH > 1) ? $clog2(IDX_BATCH) : 1;

  localparam logic [1:0]        MODE_RR   = 2'd1;
  localparam logic [1:0]        MODE_ONE  = 2'd2;
  localparam logic [CNT_W-1:0]  MAX_FLAT  = CNT_W'(IDX_DEPTH);
  localparam logic [CNT_W-1:0]  MAX_RR    = CNT_W'(IDX_DEPTH * BANK_NUM);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(IDX_BATCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UNPACK,
    S_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_reg,   state_next;
  logic [CNT_W-1:0]    n_reg,       n_next;        // entry being presented
  logic [CNT_W-1:0]    num_reg,     num_next;      // latched, clamped N
  logic [SLOT_W-1:0]   slot_reg,    slot_next;     // position inside beat
  logic [1:0]          mode_reg,    mode_next;
  logic [BANK_W-1:0]   bank_reg,    bank_next;
  logic [DDR_W-1:0]    hold_reg,    hold_next;     // remaining beat entries
  logic [ENT_W-1:0]    wr_data_reg, wr_data_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [BANK_NUM-1:0] wr_en_reg,   wr_en_next;

  logic ready_c;

  // -------------------------------------------------------------------------
  // Capacity clamp applied when start latches the configuration
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] conf_max;
  logic [CNT_W-1:0] conf_num_clamped;

  assign conf_max         = (conf_mode == MODE_RR) ? MAX_RR : MAX_FLAT;
  assign conf_num_clamped = (conf_idx_num > conf_max) ? conf_max : conf_idx_num;

  // -------------------------------------------------------------------------
  // Entry mapping
  //
  // Whenever the output registers are loaded, the entry that lands there is
  // n_reg when coming from WAIT (n already points at the next entry) and
  // n_reg+1 when advancing inside UNPACK.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    map_n;
  logic [BANK_W-1:0]   map_bank;
  logic [ADDR_W-1:0]   map_addr;
  logic [BANK_NUM-1:0] bank_onehot;
  logic [BANK_NUM-1:0] map_en;

  assign map_n = (state_reg == S_UNPACK) ? (n_reg + CNT_W'(1)) : n_reg;

  always_comb begin
    map_bank = bank_reg;
    map_addr = ADDR_W'(map_n);
    if (mode_reg == MODE_RR) begin
      // Low bits pick the bank, the rest is the row inside that bank.
      map_bank = BANK_W'(map_n);
      map_addr = ADDR_W'(map_n >> BANK_W);
    end
  end

  generate
    for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank_dec
      assign bank_onehot[gi] = (map_bank == BANK_W'(gi));
    end
  endgenerate

  // Modes 0 and 3 broadcast to every bank.
  assign map_en = ((mode_reg == MODE_RR) || (mode_reg == MODE_ONE)) ? bank_onehot : '1;

  // -------------------------------------------------------------------------
  // Status decodes
  // -------------------------------------------------------------------------
  logic slot_last;
  logic entry_last;

  assign slot_last  = (slot_reg == SLOT_LAST);
  assign entry_last = (n_reg == (num_reg - CNT_W'(1)));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    num_next     = num_reg;
    slot_next    = slot_reg;
    mode_next    = mode_reg;
    bank_next    = bank_reg;
    hold_next    = hold_reg;
    wr_data_next = wr_data_reg;
    wr_addr_next = wr_addr_reg;
    wr_en_next   = '0;          // a strobe lives exactly one cycle
    ready_c      = 1'b0;

    if (start) begin
      // start aborts whatever is in flight, from any state.  ready_c stays
      // low in this cycle so no beat is swallowed by the aborted load.
      mode_next  = conf_mode;
      bank_next  = conf_bank;
      num_next   = conf_num_clamped;
      n_next     = '0;
      slot_next  = '0;
      hold_next  = '0;
      state_next = (conf_num_clamped == '0) ? S_DONE : S_WAIT;
    end else begin
      case (state_reg)
        S_WAIT: begin
          ready_c = 1'b1;
          if (bus.ddr_valid) begin
            // Entry 0 goes straight to the outputs; the rest is kept in the
            // holding register, pre-shifted so the next entry sits at bit 0.
            wr_data_next = bus.ddr_data[ENT_W-1:0];
            hold_next    = bus.ddr_data >> ENT_W;
            wr_addr_next = map_addr;
            wr_en_next   = map_en;
            slot_next    = '0;
            state_next   = S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (entry_last) begin
            // Remaining slots of this beat are dropped.
            state_next = S_DONE;
          end else if (!slot_last) begin
            wr_data_next = hold_reg[ENT_W-1:0];
            hold_next    = hold_reg >> ENT_W;
            wr_addr_next = map_addr;
            wr_en_next   = map_en;
            slot_next    = slot_reg + SLOT_W'(1);
            n_next       = n_reg + CNT_W'(1);
          end else begin
            // Beat exhausted: accept the next one in the same cycle so a
            // continuous stream produces one write per cycle with no bubble.
            ready_c = 1'b1;
            n_next  = n_reg + CNT_W'(1);
            if (bus.ddr_valid) begin
              wr_data_next = bus.ddr_data[ENT_W-1:0];
              hold_next    = bus.ddr_data >> ENT_W;
              wr_addr_next = map_addr;
              wr_en_next   = map_en;
              slot_next    = '0;
            end else begin
              state_next = S_WAIT;
            end
          end
        end

        default: begin
          // IDLE and DONE only leave on start.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      n_reg       <= '0;
      num_reg     <= '0;
      slot_reg    <= '0;
      mode_reg    <= '0;
      bank_reg    <= '0;
      hold_reg    <= '0;
      wr_data_reg <= '0;
      wr_addr_reg <= '0;
      wr_en_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      num_reg     <= num_next;
      slot_reg    <= slot_next;
      mode_reg    <= mode_next;
      bank_reg    <= bank_next;
      hold_reg    <= hold_next;
      wr_data_reg <= wr_data_next;
      wr_addr_reg <= wr_addr_next;
      wr_en_reg   <= wr_en_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign done            = (state_reg == S_DONE);
  assign bus.ddr_ready   = ready_c;
  assign bus.idx_wr_data = wr_data_reg;
  assign bus.idx_wr_addr = wr_addr_reg;
  assign bus.idx_wr_en   = wr_en_reg;

endmodule

// File: tb/tb_ddr2idxbuf.sv
// ---------------------------------------------------------------------------
// tb_ddr2idxbuf
//
// Directed sequence of loads with random beat contents (and random ddr_valid
// for the long round-robin run).  Observed writes are collected per load and
// compared against a reference built directly from the mapping rules:
// entry n = slot n%IDX_BATCH of beat n/IDX_BATCH, placed at bank/addr given
// by the mode.
// ---------------------------------------------------------------------------
module tb_ddr2idxbuf;

  localparam int DDR_W     = 512;
  localparam int IDX_W     = 16;
  localparam int BANK_NUM  = 4;
  localparam int IDX_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int CNT_W     = 11;
  localparam int ENT_W     = 2 * IDX_W;
  localparam int BATCH     = DDR_W / ENT_W;
  localparam int NBEATS    = 128;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                done;
  logic [1:0]          conf_mode = '0;
  logic [1:0]          conf_bank = '0;
  logic [CNT_W-1:0]    conf_idx_num = '0;

  ddr2idxbuf_if #(.DDR_W(DDR_W), .IDX_W(IDX_W), .BANK_NUM(BANK_NUM), .ADDR_W(ADDR_W)) bus ();

  ddr2idxbuf #(
    .DDR_W(DDR_W), .IDX_W(IDX_W), .BANK_NUM(BANK_NUM), .IDX_DEPTH(IDX_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .done         (done),
    .conf_mode    (conf_mode),
    .conf_bank    (conf_bank),
    .conf_idx_num (conf_idx_num),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DDR_W-1:0] beats [NBEATS];
  int               beat_ptr;
  int               beat_base;

  logic [3:0]       obs_en   [$];
  logic [ADDR_W-1:0] obs_addr [$];
  logic [ENT_W-1:0] obs_data [$];
  int               obs_cyc  [$];
  int               xfers;
  int               done_cyc;
  int               ready_after_done;
  logic             first_ready;
  logic [3:0]       first_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_beats();
    for (int i = 0; i < NBEATS; i++)
      for (int w = 0; w < DDR_W / 32; w++)
        beats[i][w*32 +: 32] = $urandom;
    beat_ptr = 0;
  endtask

  task automatic do_start(input int mode, input int bank, input int n);
    @(posedge clk); #1;
    start        = 1'b1;
    conf_mode    = mode[1:0];
    conf_bank    = bank[1:0];
    conf_idx_num = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives the DDR stream and records writes, cycle by cycle, starting in
  // the first cycle after start.  vmode: 0 = always valid, 1 = random valid,
  // 2 = valid withheld for three ready cycles after the first beat.
  task automatic collect(input int vmode, input int wr_limit, input int budget);
    int   cyc;
    int   gap_left;
    logic xfer;
    obs_en.delete(); obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    xfers = 0; done_cyc = -1; ready_after_done = 0; gap_left = 3; cyc = 0;
    beat_base = beat_ptr;
    while (1) begin
      bus.ddr_data = beats[beat_ptr % NBEATS];
      case (vmode)
        0:       bus.ddr_valid = 1'b1;
        1:       bus.ddr_valid = ($urandom_range(0, 99) < 55);
        default: bus.ddr_valid = !(xfers == 1 && gap_left > 0);
      endcase
      @(negedge clk);
      xfer = bus.ddr_valid && bus.ddr_ready;
      if (cyc == 0) begin
        first_ready = bus.ddr_ready;
        first_en    = bus.idx_wr_en;
      end
      if (bus.idx_wr_en != '0) begin
        obs_en.push_back(bus.idx_wr_en);
        obs_addr.push_back(bus.idx_wr_addr);
        obs_data.push_back(bus.idx_wr_data);
        obs_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done && bus.ddr_ready) ready_after_done++;
      if (vmode == 2 && xfers == 1 && bus.ddr_ready && !bus.ddr_valid && gap_left > 0)
        gap_left--;
      if (xfer) begin
        xfers++;
        beat_ptr++;
      end
      cyc++;
      if (wr_limit > 0 && obs_en.size() >= wr_limit) break;
      if (done_cyc >= 0 && cyc > done_cyc + 4) break;
      if (cyc >= budget) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_load(input string name, input int mode, input int bank,
                            input int n_conf, input int vmode);
    int               lim, nexp, nbeats, eaddr, last_c, maxgap, d;
    logic [3:0]       een;
    logic [DDR_W-1:0] bt;
    logic [ENT_W-1:0] edata;
    logic [63:0]      o, e;
    lim    = (mode == 1) ? IDX_DEPTH * BANK_NUM : IDX_DEPTH;
    nexp   = (n_conf > lim) ? lim : n_conf;
    nbeats = (nexp + BATCH - 1) / BATCH;
    chk({name, ".writes"}, obs_en.size(), nexp);
    chk({name, ".beats"}, xfers, nbeats);
    chk({name, ".done_seen"}, done_cyc >= 0, 1);
    chk({name, ".ready_in_done"}, ready_after_done, 0);
    chk({name, ".first_en"}, first_en, 0);
    chk({name, ".first_ready"}, first_ready, nexp > 0);
    for (int n = 0; n < nexp && n < obs_en.size(); n++) begin
      case (mode)
        1:       begin een = 4'b1 << (n % BANK_NUM); eaddr = n / BANK_NUM; end
        2:       begin een = 4'b1 << bank;           eaddr = n;            end
        default: begin een = 4'hF;                   eaddr = n;            end
      endcase
      bt    = beats[(beat_base + n / BATCH) % NBEATS];
      edata = bt[(n % BATCH) * ENT_W +: ENT_W];
      o = {20'd0, obs_en[n], obs_addr[n], obs_data[n]};
      e = {20'd0, een, eaddr[ADDR_W-1:0], edata};
      chk($sformatf("%s.entry%0d{en,addr,data}", name, n), o, e);
      if (o !== e) break;
    end
    last_c = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] : -10;
    if (nexp > 0) chk({name, ".done_after_last"}, done_cyc, last_c + 1);
    else          chk({name, ".done_next_cycle"}, done_cyc, 0);
    if (vmode == 0 && obs_cyc.size() > 0) begin
      chk({name, ".first_wr_cycle"}, obs_cyc[0], 1);
      chk({name, ".no_bubble_span"}, last_c - obs_cyc[0], nexp - 1);
    end
    if (vmode == 2) begin
      maxgap = 0;
      for (int i = 1; i < obs_cyc.size(); i++) begin
        d = obs_cyc[i] - obs_cyc[i-1] - 1;
        if (d > maxgap) maxgap = d;
      end
      chk({name, ".strobe_gap"}, maxgap, 3);
    end
    $display("load %s mode=%0d N=%0d: %0d writes, %0d beats, done at +%0d",
             name, mode, n_conf, obs_en.size(), xfers, done_cyc);
  endtask

  task automatic run(input string name, input int mode, input int bank,
                     input int n, input int vmode);
    fill_beats();
    do_start(mode, bank, n);
    collect(vmode, 0, 5000);
    check_load(name, mode, bank, n, vmode);
  endtask

  logic [3:0] en_before;

  initial begin
    bus.ddr_valid = 1'b0;
    bus.ddr_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.done", done, 0);
    chk("reset.ddr_ready", bus.ddr_ready, 0);
    chk("reset.wr_en", bus.idx_wr_en, 0);
    chk("reset.wr_addr", bus.idx_wr_addr, 0);
    chk("reset.wr_data", bus.idx_wr_data, 0);
    rst_n = 1'b1;
    bus.ddr_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.done", done, 0);
    chk("idle.ddr_ready", bus.ddr_ready, 0);

    run("m0_n16", 0, 0, 16, 0);

    run("m1_n37", 1, 0, 37, 0);
    chk("m1_n37.entry36_en", obs_en[36], 4'b0001);
    chk("m1_n37.entry36_addr", obs_addr[36], 9);

    run("m2_gap", 2, 2, 20, 2);

    run("n0", 0, 0, 0, 0);

    run("m0_clamp", 0, 0, 2000, 0);

    run("m3_bcast", 3, 1, 5, 0);

    // Asynchronous reset in the middle of unpacking
    fill_beats();
    do_start(0, 0, 64);
    collect(0, 5, 200);
    #2;
    en_before = bus.idx_wr_en;
    rst_n = 1'b0;
    #1;
    chk("arst.en_before", en_before, 4'hF);
    chk("arst.wr_en", bus.idx_wr_en, 0);
    chk("arst.wr_addr", bus.idx_wr_addr, 0);
    chk("arst.wr_data", bus.idx_wr_data, 0);
    chk("arst.ddr_ready", bus.ddr_ready, 0);
    chk("arst.done", done, 0);
    $display("async reset applied mid-load after %0d writes", obs_en.size());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort by start in the middle of a load, then a fresh round-robin load
    fill_beats();
    do_start(0, 0, 64);
    collect(0, 5, 200);
    do_start(1, 0, 20);
    collect(0, 0, 500);
    check_load("abort_restart", 1, 0, 20, 0);

    run("m1_rand", 1, 0, 1024, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
